// File: rtl/pipe_stage_reg_if.sv
// Bundle of the stage-boundary signals between the producer/consumer side and
// the boundary register. The master drives stage inputs, the slave is the register.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MC_W   = 66,
    parameter int unsigned CNT_W  = 8
);
    logic [5:0]        stall;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [MC_W-1:0]   mc_i;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [MC_W-1:0]   mc_o;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output stall, flush, in_valid, in_data, mc_i,
        input  out_valid, out_data, mc_o, stall_cnt
    );

    modport slave (
        input  stall, flush, in_valid, in_data, mc_i,
        output out_valid, out_data, mc_o, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register: opaque payload plus valid, stall/flush
// handling, multi-cycle state carry-back and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int unsigned       MC_W      = 66,
    parameter int unsigned       STAGE     = 3,
    parameter int unsigned       CNT_W     = 8
) (
    input logic              clk,
    input logic              rst,
    pipe_stage_reg_if.slave  bus
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic              s_up;
    logic              s_dn;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [MC_W-1:0]   mc_q, mc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign s_up = bus.stall[STAGE];
    assign s_dn = bus.stall[STAGE+1];

    // Next-state decode in priority order: flush, bubble, pass, hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        mc_d    = mc_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            // The killed instruction's partial multi-cycle state is dropped too.
            valid_d = 1'b0;
            data_d  = NOP_VALUE;
            mc_d    = '0;
            cnt_d   = '0;
        end else if (s_up && !s_dn) begin
            // Bubble: upstream keeps its instruction and gets its partial result back.
            valid_d = 1'b0;
            data_d  = NOP_VALUE;
            mc_d    = bus.mc_i;
            cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end else if (!s_up) begin
            // Pass; s_dn=1 here is an illegal vector and is treated the same way.
            valid_d = bus.in_valid;
            data_d  = bus.in_data;
            mc_d    = '0;
            cnt_d   = '0;
        end else begin
            // Hold: stall belongs to downstream, so the counter freezes.
            mc_d    = bus.mc_i;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VALUE;
            mc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mc_q    <= mc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.mc_o      = mc_q;
    assign bus.stall_cnt = cnt_q;

    // Stalls propagate upstream, so a stalled downstream with a running upstream is a bug.
    illegal_stall_vector : assert property (@(posedge clk) disable iff (rst) !(!s_up && s_dn));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: main instance (STAGE=3, non-zero NOP)
// plus a CNT_W=2 instance sharing the same stimulus for counter saturation.
module tb_pipe_stage_reg;

    localparam int unsigned DataW = 32;
    localparam int unsigned McW   = 66;
    localparam logic [DataW-1:0] NopVal = 32'h0BAD_F00D;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pipe_stage_reg_if #(.DATA_W(DataW), .MC_W(McW), .CNT_W(8)) bus ();
    pipe_stage_reg_if #(.DATA_W(DataW), .MC_W(McW), .CNT_W(2)) sat_bus ();

    pipe_stage_reg #(
        .DATA_W    (DataW),
        .NOP_VALUE (NopVal),
        .MC_W      (McW),
        .STAGE     (3),
        .CNT_W     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    pipe_stage_reg #(
        .DATA_W    (DataW),
        .NOP_VALUE (NopVal),
        .MC_W      (McW),
        .STAGE     (3),
        .CNT_W     (2)
    ) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sat_bus.slave)
    );

    assign sat_bus.stall    = bus.stall;
    assign sat_bus.flush    = bus.flush;
    assign sat_bus.in_valid = bus.in_valid;
    assign sat_bus.in_data  = bus.in_data;
    assign sat_bus.mc_i     = bus.mc_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, ".valid"}, 128'(bus.out_valid), 128'(0));
        check_eq({tag, ".data"},  128'(bus.out_data),  128'(NopVal));
        check_eq({tag, ".mc"},    128'(bus.mc_o),      128'(0));
        check_eq({tag, ".cnt"},   128'(bus.stall_cnt), 128'(0));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset with garbage on every input, including a bubble-looking stall.
        rst          = 1'b1;
        bus.stall    = 6'b101010;
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1234_5678;
        bus.mc_i     = 66'h3_FFFF_0000_1111_2222;
        step();
        step();
        check_cleared("reset");
        check_eq("reset.sat_cnt", 128'(sat_bus.stall_cnt), 128'(0));

        // Release reset: outputs keep reset values until the next edge.
        rst          = 1'b0;
        bus.stall    = 6'b000000;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        bus.mc_i     = '0;
        check_cleared("post_reset");
        step();
        check_eq("pass.valid", 128'(bus.out_valid), 128'(1));
        check_eq("pass.data",  128'(bus.out_data),  128'(32'hDEAD_BEEF));

        // Bubble with multi-cycle carry.
        for (int i = 1; i <= 3; i++) begin
            bus.stall   = 6'b001000;
            bus.in_data = 32'h1111_0000 + 32'(i);
            bus.mc_i    = 66'(i);
            step();
            check_eq($sformatf("bubble%0d.valid", i), 128'(bus.out_valid), 128'(0));
            check_eq($sformatf("bubble%0d.data", i),  128'(bus.out_data),  128'(NopVal));
            check_eq($sformatf("bubble%0d.mc", i),    128'(bus.mc_o),      128'(i));
            check_eq($sformatf("bubble%0d.cnt", i),   128'(bus.stall_cnt), 128'(i));
        end
        bus.stall    = 6'b000000;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0055;
        bus.mc_i     = 66'h2_0000_0000_0000_0009;
        step();
        check_eq("after_bubble.valid", 128'(bus.out_valid), 128'(1));
        check_eq("after_bubble.data",  128'(bus.out_data),  128'(32'h55));
        check_eq("after_bubble.mc",    128'(bus.mc_o),      128'(0));
        check_eq("after_bubble.cnt",   128'(bus.stall_cnt), 128'(0));

        // Hold: downstream stalled, register keeps its contents.
        bus.in_data = 32'hA5A5_A5A5;
        step();
        check_eq("hold_load.data", 128'(bus.out_data), 128'(32'hA5A5_A5A5));
        for (int i = 0; i < 4; i++) begin
            bus.stall    = 6'b011000;
            bus.in_valid = 1'(i & 1);
            bus.in_data  = 32'hCC00_0000 + 32'(i);
            bus.mc_i     = 66'h2_0000_0000_0000_0010 + 66'(i);
            step();
            check_eq($sformatf("hold%0d.data", i),  128'(bus.out_data),  128'(32'hA5A5_A5A5));
            check_eq($sformatf("hold%0d.valid", i), 128'(bus.out_valid), 128'(1));
            check_eq($sformatf("hold%0d.cnt", i),   128'(bus.stall_cnt), 128'(0));
            check_eq($sformatf("hold%0d.mc", i),    128'(bus.mc_o),
                     128'(66'h2_0000_0000_0000_0010 + 66'(i)));
        end

        // Flush beats a simultaneous bubble; out_valid was 1 before.
        bus.stall = 6'b001000;
        bus.flush = 1'b1;
        bus.mc_i  = 66'h3;
        step();
        check_cleared("flush");
        bus.flush = 1'b0;

        // Saturation: bubble held 6 cycles; CNT_W=2 saturates at 3.
        for (int i = 1; i <= 6; i++) begin
            bus.stall = 6'b001000;
            bus.mc_i  = 66'(i);
            step();
            check_eq($sformatf("sat%0d.sat_cnt", i), 128'(sat_bus.stall_cnt),
                     128'((i > 3) ? 3 : i));
            check_eq($sformatf("sat%0d.cnt", i), 128'(bus.stall_cnt), 128'(i));
        end

        // Pass with in_valid=0: payload still loaded, valid low.
        bus.stall    = 6'b000000;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hCAFE_F00D;
        step();
        check_eq("pass_inv.valid", 128'(bus.out_valid), 128'(0));
        check_eq("pass_inv.data",  128'(bus.out_data),  128'(32'hCAFE_F00D));
        check_eq("pass_inv.cnt",   128'(bus.stall_cnt), 128'(0));

        // Reset mid multi-cycle op.
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            bus.stall = 6'b001000;
            bus.mc_i  = 66'h7;
            step();
            check_eq($sformatf("midop%0d.mc", i),  128'(bus.mc_o),      128'(7));
            check_eq($sformatf("midop%0d.cnt", i), 128'(bus.stall_cnt), 128'(i));
        end
        rst = 1'b1;
        step();
        check_cleared("midop_reset");
        rst       = 1'b0;
        bus.stall = 6'b000000;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
